// File: rtl/gray_conv_pkg.sv
// Shared types and helpers for the Gray-code
// converter arbiter.
package gray_conv_pkg;

  localparam int ID_W  = 2;
  localparam int MAX_W = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } oreg_e;

  function automatic logic [MAX_W-1:0] bin2gray(
    input logic [MAX_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_conv_arbiter_enc.sv
// Purely combinational binary-to-Gray encoder
// shared by all requesters.
module gray_enc #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] bin,
  output logic [DATA_W-1:0] gray
);
  import gray_conv_pkg::*;

  logic [MAX_W-1:0] g_full;

  // widen, encode, then trim back to DATA_W
  always_comb begin
    g_full = bin2gray(MAX_W'(bin));
    gray   = g_full[DATA_W-1:0];
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter feeding one shared Gray
// encoder through a one-entry output register.
module gray_conv_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 4,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      resp_valid,
  output logic [DATA_W-1:0]         resp_gray,
  output logic [ID_W-1:0]           resp_id,
  input  logic                      resp_ready
);
  import gray_conv_pkg::*;

  oreg_e           state;
  oreg_e           state_nx;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] grant_idx;
  logic            found;
  logic            can_accept;
  logic            accept;
  int              scan_idx;
  logic [DATA_W-1:0] sel_word;
  logic [DATA_W-1:0] sel_gray;

  // scan from the slot after the last winner
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[scan_idx]) begin
        found     = 1'b1;
        grant_idx = ID_W'(scan_idx);
      end
    end
  end

  // handshake; nothing is accepted while reset is held
  always_comb begin
    can_accept = (state == EMPTY) | resp_ready;
    accept     = found & can_accept & rst_n;
    req_ready  = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
    sel_word = req_data[int'(grant_idx)*DATA_W +: DATA_W];
  end

  gray_enc #(
    .DATA_W (DATA_W)
  ) u_enc (
    .bin  (sel_word),
    .gray (sel_gray)
  );

  // output register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;
  end

  // fill on accept, drain when consumed with no refill
  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   state_nx = accept ? FULL : EMPTY;
      FULL:    state_nx = (resp_ready && !accept) ? EMPTY : FULL;
      default: state_nx = EMPTY;
    endcase
  end

  // response valid follows the register state
  always_comb begin
    resp_valid = (state == FULL);
  end

  // capture result, id and pointer on every accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      resp_gray  <= '0;
      resp_id    <= '0;
    end else if (accept) begin
      last_grant <= grant_idx;
      resp_gray  <= sel_gray;
      resp_id    <= grant_idx;
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed and scoreboarded bench for the
// Gray converter arbiter.
module tb_gray_conv_arbiter;

  localparam int NR = 4;
  localparam int DW = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              resp_valid;
  logic [DW-1:0]     resp_gray;
  logic [IW-1:0]     resp_id;
  logic              resp_ready;

  int n_chk  = 0;
  int n_pass = 0;

  gray_conv_arbiter #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .ID_W    (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_gray  (resp_gray),
    .resp_id    (resp_id),
    .resp_ready (resp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] d);
    req_data[i*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] ref_gray(input logic [DW-1:0] b);
    logic [DW-1:0] g;
    for (int i = 0; i < DW - 1; i++) g[i] = b[i+1] ^ b[i];
    g[DW-1] = b[DW-1];
    return g;
  endfunction

  int            exp_id [6] = '{0, 1, 2, 3, 0, 1};
  logic [DW-1:0] g_of   [4] = '{4'h1, 4'h3, 4'hA, 4'h4};

  logic [NR-1:0] pend;
  logic [DW-1:0] pdat [NR];
  int            lg;
  int            gi;
  logic          ca;
  logic [NR-1:0] exp_rdy;
  int            qid [$];
  logic [DW-1:0] qg  [$];

  initial begin
    rst_n      = 1'b1;
    req_valid  = '1;
    req_data   = '0;
    resp_ready = 1'b1;
    set_data(0, 4'b0001);
    set_data(1, 4'b0010);
    set_data(2, 4'b1100);
    set_data(3, 4'b0111);
    #1 rst_n = 1'b0;
    tick;
    tick;
    chk("rst valid", resp_valid, 0);
    chk("rst ready", req_ready, 0);
    chk("rst gray", resp_gray, 0);
    chk("rst id", resp_id, 0);
    rst_n = 1'b1;
    #1;
    chk("rel ready", req_ready, 4'b0001);
    tick;
    chk("rel id", resp_id, 0);
    chk("rel gray", resp_gray, 4'h1);

    req_valid = 4'b0100;
    set_data(2, 4'b0110);
    tick;
    chk("enc0110 gray", resp_gray, 4'b0101);
    chk("enc0110 id", resp_id, 2);
    chk("enc0110 valid", resp_valid, 1);
    set_data(2, 4'b1011);
    tick;
    chk("enc1011", resp_gray, 4'b1110);
    set_data(2, 4'b1111);
    tick;
    chk("enc1111", resp_gray, 4'b1000);
    set_data(2, 4'b0000);
    tick;
    chk("enc0000", resp_gray, 4'b0000);
    chk("enc0000 valid", resp_valid, 1);
    set_data(2, 4'b1011);
    tick;
    chk("pre-rst gray", resp_gray, 4'b1110);

    resp_ready = 1'b0;
    req_valid  = '1;
    set_data(2, 4'b1100);
    rst_n = 1'b0;
    #1;
    chk("mid-rst valid", resp_valid, 0);
    chk("mid-rst gray", resp_gray, 0);
    chk("mid-rst id", resp_id, 0);
    chk("mid-rst ready", req_ready, 0);
    tick;
    chk("mid-rst held ready", req_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("mid-rel ready", req_ready, 4'b0001);
    resp_ready = 1'b1;

    for (int k = 0; k < 6; k++) begin
      tick;
      chk("rr id", resp_id, exp_id[k]);
      chk("rr gray", resp_gray, g_of[exp_id[k]]);
      chk("rr valid", resp_valid, 1);
    end

    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp ready", req_ready, 0);
      chk("bp id", resp_id, 1);
      chk("bp gray", resp_gray, 4'h3);
      chk("bp valid", resp_valid, 1);
      tick;
    end
    resp_ready = 1'b1;
    #1;
    chk("bp release ready", req_ready, 4'b0100);
    tick;
    chk("bp release id", resp_id, 2);
    chk("bp release gray", resp_gray, 4'hA);

    req_valid = 4'b0010;
    tick;
    chk("fair setup id", resp_id, 1);
    req_valid = 4'b1010;
    #1;
    chk("fair ready", req_ready, 4'b1000);
    tick;
    chk("fair id a", resp_id, 3);
    chk("fair gray a", resp_gray, 4'h4);
    tick;
    chk("fair id b", resp_id, 1);
    chk("fair gray b", resp_gray, 4'h3);
    tick;
    chk("fair id c", resp_id, 3);

    rst_n      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    tick;
    rst_n = 1'b1;
    pend  = '0;
    lg    = NR - 1;
    for (int i = 0; i < NR; i++) pdat[i] = '0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pdat[i] = DW'($urandom);
        end
        req_data[i*DW +: DW] = pdat[i];
      end
      req_valid  = pend;
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      chk("soak valid", resp_valid, qid.size() != 0);
      ca      = (qid.size() == 0) || resp_ready;
      exp_rdy = '0;
      gi      = -1;
      if (ca) begin
        for (int k = 1; k <= NR; k++) begin
          if (gi < 0 && pend[(lg + k) % NR]) gi = (lg + k) % NR;
        end
        if (gi >= 0) exp_rdy[gi] = 1'b1;
      end
      chk("soak ready", req_ready, exp_rdy);
      if (qid.size() != 0 && resp_ready) begin
        chk("soak id", resp_id, qid.pop_front());
        chk("soak gray", resp_gray, qg.pop_front());
      end
      if (gi >= 0) begin
        qid.push_back(gi);
        qg.push_back(ref_gray(pdat[gi]));
        pend[gi] = 1'b0;
        lg       = gi;
      end
      @(posedge clk);
      #1;
    end

    req_valid  = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    if (qid.size() != 0) begin
      chk("drain id", resp_id, qid.pop_front());
      chk("drain gray", resp_gray, qg.pop_front());
    end
    tick;
    chk("drain valid", resp_valid, 0);
    chk("drain queue", qid.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
